// File: rtl/im_sram_scheduler_if.sv
// Bundle of every signal of the item-memory scheduler apart from clk/rst:
// host load port, encoder read port, status flags, SRAM macro pins and a
// debug view of the scheduler state.
//
// Handshake rules:
//   A read request transfers on a cycle where rd_req_valid && rd_req_ready
//   are both high. The requester may raise rd_req_valid at any time. While
//   rd_req_valid is high and rd_req_ready is low, it keeps rd_addr stable.
//   The response is rd_data_valid exactly one cycle after the transfer. It
//   has no ready: the consumer must take it.
//   Host writes have no handshake. we is active-low and is honoured in the
//   cycle it is low.
interface im_sram_scheduler_if #(
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int FOLD_WIDTH      = 500
);
  logic                       we;
  logic [SRAM_ADDR_WIDTH-1:0] im_write_addr;
  logic [FOLD_WIDTH-1:0]      im_din;
  logic                       rd_req_valid;
  logic                       rd_req_ready;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr;
  logic                       rd_data_valid;
  logic [FOLD_WIDTH-1:0]      rd_data;
  logic                       im_loaded;
  logic                       addr_err;
  logic                       sram_ceb;
  logic                       sram_web;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [FOLD_WIDTH-1:0]      sram_din;
  logic [FOLD_WIDTH-1:0]      sram_dout;
  logic [1:0]                 state_dbg;

  // Scheduler side
  modport slave (
    input  we, im_write_addr, im_din, rd_req_valid, rd_addr, sram_dout,
    output rd_req_ready, rd_data_valid, rd_data, im_loaded, addr_err,
           sram_ceb, sram_web, sram_addr, sram_din, state_dbg
  );

  // Host / encoder / SRAM side
  modport master (
    output we, im_write_addr, im_din, rd_req_valid, rd_addr, sram_dout,
    input  rd_req_ready, rd_data_valid, rd_data, im_loaded, addr_err,
           sram_ceb, sram_web, sram_addr, sram_din, state_dbg
  );
endinterface

// File: rtl/im_sram_scheduler.sv
// Item-memory SRAM scheduler. It shares one single-port SRAM between host
// table loads and encoder fold reads. Host writes always win. Encoder reads
// are only accepted once the whole table (channels x folds) has been written
// since the last reset or reload start.
module im_sram_scheduler #(
  parameter int NUM_CHANNEL     = 214,
  parameter int NUM_FOLDS       = 4,
  parameter int FOLD_WIDTH      = 500,
  parameter int SRAM_ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  im_sram_scheduler_if.slave  bus
);

  localparam int DEPTH = NUM_CHANNEL * NUM_FOLDS;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // One extra bit so DEPTH == 2**SRAM_ADDR_WIDTH is still representable
  localparam logic [SRAM_ADDR_WIDTH:0] DEPTH_A  = (SRAM_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]         ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wr_count;
  logic             loaded_q;
  logic             err_q;
  logic             rd_pending;   // a read was accepted last cycle
  logic             rd_oor;       // ...and its address was out of range

  logic wr_in_range;
  logic rd_in_range;
  logic wr_acc;
  logic wr_drop;
  logic rd_hs;

  assign wr_in_range = {1'b0, bus.im_write_addr} < DEPTH_A;
  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_A;
  assign wr_acc      = !rst && !bus.we && wr_in_range;
  assign wr_drop     = !rst && !bus.we && !wr_in_range;

  // A pending host write blocks reads, so collisions always go to the host
  assign bus.rd_req_ready = (state == ST_READY) && bus.we && !rst;
  assign rd_hs            = bus.rd_req_valid && bus.rd_req_ready;

  // The response in the reset cycle is suppressed. Status shows reset values during rst.
  assign bus.rd_data_valid = rd_pending && !rst;
  assign bus.rd_data       = (bus.rd_data_valid && !rd_oor) ? bus.sram_dout : '0;
  assign bus.im_loaded     = loaded_q && !rst;
  assign bus.addr_err      = err_q && !rst;
  assign bus.state_dbg     = state;

  // SRAM pin mux: write, else in-range read, else idle with zeroed buses
  always_comb begin
    bus.sram_ceb  = 1'b1;
    bus.sram_web  = 1'b1;
    bus.sram_addr = '0;
    bus.sram_din  = '0;
    if (wr_acc) begin
      bus.sram_ceb  = 1'b0;
      bus.sram_web  = 1'b0;
      bus.sram_addr = bus.im_write_addr;
      bus.sram_din  = bus.im_din;
    end else if (rd_hs && rd_in_range) begin
      bus.sram_ceb  = 1'b0;
      bus.sram_addr = bus.rd_addr;
    end
  end

  // Load-tracking FSM, sticky error flag and one-deep read response pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      wr_count   <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_pending <= 1'b0;
      rd_oor     <= 1'b0;
    end else begin
      rd_pending <= rd_hs;
      rd_oor     <= rd_hs && !rd_in_range;

      if (wr_drop || (rd_hs && !rd_in_range)) begin
        err_q <= 1'b1;
      end

      if (wr_acc) begin
        case (state)
          ST_EMPTY: begin
            state    <= ST_LOAD;
            wr_count <= ONE_CNT;
          end
          ST_LOAD: begin
            if (wr_count != FULL_CNT) begin
              wr_count <= wr_count + ONE_CNT;
            end
            if (wr_count == LAST_CNT) begin
              state    <= ST_READY;
              loaded_q <= 1'b1;
            end
          end
          ST_READY: begin
            // Any new write starts a reload, and it is counted as the first word
            state    <= ST_LOAD;
            wr_count <= ONE_CNT;
            loaded_q <= 1'b0;
          end
          default: begin
            state    <= ST_EMPTY;
            wr_count <= '0;
            loaded_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_sram_scheduler.sv
// Testbench for im_sram_scheduler. It models the SRAM macro and keeps a reference
// model of the table-load rules: writes since the last reload start, a loaded flag
// and a shadow copy of the memory. A scoreboard queue holds the read responses.
module tb_im_sram_scheduler;

  localparam int AW    = 10;
  localparam int FW    = 500;
  localparam int DEPTH = 214 * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  im_sram_scheduler_if #(.SRAM_ADDR_WIDTH(AW), .FOLD_WIDTH(FW)) bus ();

  im_sram_scheduler #(
    .NUM_CHANNEL(214), .NUM_FOLDS(4), .FOLD_WIDTH(FW), .SRAM_ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- SRAM macro model (1-cycle read latency) ----------------
  logic [FW-1:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!bus.sram_ceb) begin
      if (!bus.sram_web) sram_mem[bus.sram_addr] <= bus.sram_din;
      else               bus.sram_dout <= sram_mem[bus.sram_addr];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] model_mem [DEPTH];
  int  m_count;
  bit  m_loaded;
  bit  m_err;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  function automatic void check(input string name, input logic [FW-1:0] act,
                                input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [FW-1:0] rand_word();
    logic [FW-1:0] w = '0;
    for (int i = 0; i < (FW + 31) / 32; i++) w = (w << 32) | FW'($urandom());
    return w;
  endfunction

  // Monitor: a response is due exactly one cycle after each accepted read
  always @(negedge clk) begin
    if (mon_en) begin
      logic          exp_valid;
      logic [FW-1:0] e;
      exp_valid = (exp_q.size() != 0);
      e = exp_valid ? exp_q.pop_front() : '0;
      check("rd_data_valid", FW'(bus.rd_data_valid), FW'(exp_valid));
      check("rd_data", bus.rd_data, e);
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge. It drives one cycle of inputs and checks the
  // combinational outputs at the falling edge. After the next rising edge it
  // advances the reference model.
  task automatic tick(input bit r, input bit w_n, input int wa, input logic [FW-1:0] wd,
                      input bit rv, input int ra);
    bit exp_ready, wr_acc, rd_hs;
    rst               = r;
    bus.we            = w_n;
    bus.im_write_addr = AW'(wa);
    bus.im_din        = wd;
    bus.rd_req_valid  = rv;
    bus.rd_addr       = AW'(ra);
    if (r) exp_q.delete();   // reset discards any in-flight response
    exp_ready = !r && m_loaded && w_n;
    wr_acc    = !r && !w_n && (wa < DEPTH);
    rd_hs     = rv && exp_ready;
    @(negedge clk);
    check("rd_req_ready", FW'(bus.rd_req_ready), FW'(exp_ready));
    check("im_loaded",    FW'(bus.im_loaded),    FW'(!r && m_loaded));
    check("addr_err",     FW'(bus.addr_err),     FW'(!r && m_err));
    if (wr_acc) begin
      check("sram_ceb_wr",  FW'(bus.sram_ceb),  FW'(0));
      check("sram_web_wr",  FW'(bus.sram_web),  FW'(0));
      check("sram_addr_wr", FW'(bus.sram_addr), FW'(wa));
      check("sram_din_wr",  bus.sram_din, wd);
    end else if (rd_hs && ra < DEPTH) begin
      check("sram_ceb_rd",  FW'(bus.sram_ceb),  FW'(0));
      check("sram_web_rd",  FW'(bus.sram_web),  FW'(1));
      check("sram_addr_rd", FW'(bus.sram_addr), FW'(ra));
    end else begin
      check("sram_ceb_idle",  FW'(bus.sram_ceb),  FW'(1));
      check("sram_web_idle",  FW'(bus.sram_web),  FW'(1));
      check("sram_addr_idle", FW'(bus.sram_addr), FW'(0));
      check("sram_din_idle",  bus.sram_din, '0);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_count  = 0;
      m_loaded = 1'b0;
      m_err    = 1'b0;
    end else begin
      if (wr_acc) begin
        model_mem[wa] = wd;
        if (m_loaded) begin
          m_loaded = 1'b0;
          m_count  = 1;
        end else begin
          m_count++;
        end
        if (m_count == DEPTH) m_loaded = 1'b1;
      end
      if (!w_n && wa >= DEPTH) m_err = 1'b1;
      if (rd_hs) begin
        exp_q.push_back(ra < DEPTH ? model_mem[ra] : '0);
        if (ra >= DEPTH) m_err = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b1, 1'b1, 0, '0, 1'b0, 0);
  endtask

  task automatic do_write(input int a, input bit rv);
    tick(1'b0, 1'b0, a, rand_word(), rv, $urandom_range(0, DEPTH - 1));
  endtask

  task automatic do_read(input int a);
    tick(1'b0, 1'b1, 0, '0, 1'b1, a);
  endtask

  task automatic do_idle();
    tick(1'b0, 1'b1, 0, '0, 1'b0, 0);
  endtask

  // Full table load in address order. Rejected read attempts are mixed in.
  task automatic full_load();
    for (int a = 0; a < DEPTH; a++) begin
      do_write(a, 1'(a % 3 == 0));
      if ($urandom_range(0, 9) == 0) do_read($urandom_range(0, DEPTH - 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.we = 1'b1; bus.im_write_addr = '0; bus.im_din = '0;
    bus.rd_req_valid = 1'b0; bus.rd_addr = '0; bus.sram_dout = '0;
    m_count = 0; m_loaded = 1'b0; m_err = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset(2);

    // T1: reads before any write are never accepted
    for (int i = 0; i < 6; i++) do_read($urandom_range(0, DEPTH - 1));

    // T2: full load, loaded flag rises the cycle after the last write
    for (int a = 0; a < DEPTH; a++) do_write(a, 1'(a % 2));
    do_idle();

    // T3: single read then back-to-back sweep
    do_read(5);
    for (int a = 0; a < DEPTH; a++) do_read(a);
    do_idle();

    // T4: write/read collision starts a reload; 855 more writes complete it
    do_write(10, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) do_write($urandom_range(0, DEPTH - 1), 1'b0);
    do_idle();
    for (int i = 0; i < 20; i++) do_read($urandom_range(0, DEPTH - 1));

    // T5: out-of-range write and read
    do_write(900, 1'b0);
    do_idle();
    do_read(1000);
    do_read(3);
    do_idle();

    // T6: reset right after a read handshake, then blocked until reload
    do_read(7);
    do_reset(1);
    for (int i = 0; i < 5; i++) do_read($urandom_range(0, DEPTH - 1));
    full_load();
    do_idle();

    // Randomised traffic: repeated reloads with mixed reads, idles and bad addresses
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 200; i++) begin
        int sel = $urandom_range(0, 99);
        if (sel < 70)      do_read($urandom_range(0, DEPTH - 1));
        else if (sel < 75) do_read($urandom_range(DEPTH, (1 << AW) - 1));
        else if (sel < 77) do_write($urandom_range(DEPTH, (1 << AW) - 1), 1'b1);
        else               tick(1'b0, 1'b1, 0, '0, 1'b0, $urandom_range(0, DEPTH - 1));
      end
      do_write($urandom_range(0, DEPTH - 1), 1'b1);
      full_load();
    end
    for (int i = 0; i < 50; i++) do_read($urandom_range(0, DEPTH - 1));

    for (int i = 0; i < 3; i++) do_idle();
    check("exp_q_drained", FW'(exp_q.size()), FW'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
